// File: rtl/counter8_pkg.sv
// Shared definitions for the counter8 datapath: state width, reset value and state type.
package counter8_pkg;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_RST = 3'b000;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/register3_r_dff_r.sv
// Single-bit D flip-flop with asynchronous active-low clear to RST_VAL.
module register3_r_dff_r #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= RST_VAL;
        else          q <= d;
    end

endmodule

// File: rtl/register3_r.sv
// WIDTH-bit state register for counter8, built from per-bit resettable flops.
// Optional load enable via REGISTER3_R_LOAD_EN (adds the en port).
module register3_r
    import counter8_pkg::*;
#(
    parameter int               WIDTH   = CNT_W,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(CNT_RST)
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef REGISTER3_R_LOAD_EN
    input  logic             en,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_nxt;

`ifdef REGISTER3_R_LOAD_EN
    // Hold is a data-path recirculation mux; the clock is never gated.
    assign d_nxt = en ? d : q;
`else
    assign d_nxt = d;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        register3_r_dff_r #(
            .RST_VAL(RST_VAL[i])
        ) u_dff (
            .clk    (clk),
            .reset_n(reset_n),
            .d      (d_nxt[i]),
            .q      (q[i])
        );
    end

endmodule

// File: tb/tb_register3_r.sv
// Directed bench for register3_r: reset, loads, async clear, glitch immunity, optional enable.
`timescale 1ns/1ps
module tb_register3_r;
    import counter8_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    cnt_t d;
    cnt_t q;

    int n_vec = 0;
    int n_err = 0;

    register3_r dut (
        .clk    (clk),
        .reset_n(reset_n),
`ifdef REGISTER3_R_LOAD_EN
        .en     (en),
`endif
        .d      (d),
        .q      (q)
    );

    always #5 clk = ~clk;

    task automatic at(input int t);
        #(t - int'($time));
    endtask

    task automatic check(input string tag, input cnt_t exp);
        n_vec++;
        assert (q === exp) else begin
            n_err++;
            $error("FAIL %s: q=%b expected=%b at %0t", tag, q, exp, $time);
        end
    endtask

    initial begin
        en      = 1'b1;
        reset_n = 1'b0;
        d       = 3'b000;
        at(1);   check("por_reset", 3'b000);
        at(3);   reset_n = 1'b1;
        at(6);   check("post_release_edge", 3'b000);
        at(13);  d = 3'b101;
        at(14);  check("no_change_before_edge", 3'b000);
        at(16);  check("load_101", 3'b101);
        at(23);  d = 3'b111;
        at(26);  check("load_111", 3'b111);
        at(33);  d = 3'b010;
        at(36);  check("load_010", 3'b010);
        at(43);  reset_n = 1'b0;
        at(44);  check("async_clear", 3'b000);
        d = 3'b111;
        at(46);  check("reset_hold_45", 3'b000);
        at(56);  check("reset_hold_55", 3'b000);
        at(58);  reset_n = 1'b1;
        at(66);  check("first_load_after_reset", 3'b111);
        at(71);  d = 3'b000;
        at(72);  d = 3'b111;
        at(73);  d = 3'b000;
        at(74);  check("glitch_no_change", 3'b111);
        at(76);  check("glitch_sampled", 3'b000);
        d = 3'b101;
        at(80);  reset_n = 1'b0;
        at(81);  check("async_clear_low_phase", 3'b000);
        at(87);  reset_n = 1'b1;
        at(96);  check("load_after_second_reset", 3'b101);
`ifdef REGISTER3_R_LOAD_EN
        at(97);  en = 1'b0; d = 3'b110;
        at(106); check("en0_hold", 3'b101);
        at(107); en = 1'b1;
        at(116); check("en1_load", 3'b110);
        at(117); en = 1'b0; reset_n = 1'b0;
        at(118); check("reset_overrides_en", 3'b000);
        reset_n = 1'b1;
`endif
        at(120);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
